// File: rtl/neuron_core_if.sv
// Four-phase event channels around the neuron: the weighted input channel
// (data_in/req_in/ack_in) and the spike output channel (req_out/ack_out).
interface neuron_core_if #(
    parameter int data_bits = 10
);
    logic [data_bits-1:0] data_in;
    logic                 req_in;
    logic                 ack_in;
    logic                 req_out;
    logic                 ack_out;

    // Neuron side: consumes input events, produces spikes
    modport slave (
        input  data_in,
        input  req_in,
        output ack_in,
        output req_out,
        input  ack_out
    );

    // Environment side: upstream producer plus downstream consumer
    modport master (
        output data_in,
        output req_in,
        input  ack_in,
        input  req_out,
        output ack_out
    );
endinterface

// File: rtl/neuron_core.sv
// Integrate-and-fire neuron. Weighted input events arrive on a four-phase
// channel and accumulate into a membrane potential; reaching the threshold
// emits one spike on a second four-phase channel and clears the potential.
module neuron_core #(
    parameter int thold     = 512,
    parameter int data_bits = 10,
    parameter int delay_v [2] = '{1, 1}
) (
    input  logic           clk,
    input  logic           rst,
    neuron_core_if.slave   bus
);
    localparam int POT_W = data_bits + 1;
    localparam logic [15:0]      INT_LOAD  = 16'(delay_v[0] - 1);
    localparam logic [15:0]      FIRE_LOAD = 16'(delay_v[1] - 1);
    localparam logic [POT_W-1:0] THOLD_V   = POT_W'(thold);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INTEG,
        S_ACK,
        S_FDLY,
        S_REQ,
        S_REL
    } state_t;

    state_t               state_q;
    logic [15:0]          cnt_q;
    logic [data_bits-1:0] w_q;
    logic [POT_W-1:0]     pot_q;
    logic                 fire_q;
    logic                 ack_in_q;
    logic                 req_out_q;

    logic req_meta_q, req_s_q;
    logic ack_meta_q, ack_s_q;

    // pot stays below thold between events, so this sum always fits in POT_W
    logic [POT_W-1:0] sum_d;

    // Two-flop synchronizers for the incoming handshake lines
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_meta_q <= 1'b0;
            req_s_q    <= 1'b0;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            req_meta_q <= bus.req_in;
            req_s_q    <= req_meta_q;
            ack_meta_q <= bus.ack_out;
            ack_s_q    <= ack_meta_q;
        end
    end

    // Candidate potential after integrating the latched weight
    always_comb begin
        sum_d = pot_q + {1'b0, w_q};
    end

    // Handshake sequencer with registered ack_in/req_out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            w_q       <= '0;
            pot_q     <= '0;
            fire_q    <= 1'b0;
            ack_in_q  <= 1'b0;
            req_out_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_s_q) begin
                        w_q     <= bus.data_in;
                        cnt_q   <= INT_LOAD;
                        state_q <= S_INTEG;
                    end
                end
                S_INTEG: begin
                    if (cnt_q == 16'd0) begin
                        // Equality fires; any excess above threshold is dropped
                        if (sum_d >= THOLD_V) begin
                            pot_q  <= '0;
                            fire_q <= 1'b1;
                        end else begin
                            pot_q  <= sum_d;
                            fire_q <= 1'b0;
                        end
                        ack_in_q <= 1'b1;
                        state_q  <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_ACK: begin
                    if (!req_s_q) begin
                        ack_in_q <= 1'b0;
                        if (fire_q) begin
                            cnt_q   <= FIRE_LOAD;
                            state_q <= S_FDLY;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_FDLY: begin
                    if (cnt_q == 16'd0) begin
                        req_out_q <= 1'b1;
                        state_q   <= S_REQ;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_REQ: begin
                    if (ack_s_q) begin
                        req_out_q <= 1'b0;
                        state_q   <= S_REL;
                    end
                end
                S_REL: begin
                    // Input stays blocked until downstream releases its ack
                    if (!ack_s_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack_in  = ack_in_q;
    assign bus.req_out = req_out_q;
endmodule

// File: tb/tb_neuron_core.sv
// Directed bench for neuron_core: reset, accumulation, threshold edges,
// handshake timing, a fixed event sequence against a model, and mid-event reset.
module tb_neuron_core;
    logic clk;
    logic rst;

    neuron_core_if #(.data_bits(10)) bus ();

    neuron_core #(
        .thold(512),
        .data_bits(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int proto_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overlap monitor: ack_in and req_out must never be high together
    always @(negedge clk) begin
        if (rst && bus.ack_in && bus.req_out) proto_err++;
    end

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.req_in = 1'b0;
        bus.ack_out = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Full input handshake plus, if a spike appears, the output handshake
    task automatic send_event(input logic [9:0] w, output bit fired, output bit ok);
        fired = 1'b0;
        ok = 1'b1;
        @(negedge clk);
        bus.data_in = w;
        bus.req_in = 1'b1;
        for (int i = 0; i < 50 && !bus.ack_in; i++) @(negedge clk);
        if (!bus.ack_in) ok = 1'b0;
        bus.req_in = 1'b0;
        for (int i = 0; i < 50 && bus.ack_in; i++) @(negedge clk);
        if (bus.ack_in) ok = 1'b0;
        for (int i = 0; i < 10 && !bus.req_out; i++) @(negedge clk);
        if (bus.req_out) begin
            fired = 1'b1;
            bus.ack_out = 1'b1;
            for (int i = 0; i < 50 && bus.req_out; i++) @(negedge clk);
            if (bus.req_out) ok = 1'b0;
            bus.ack_out = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req_in = 1'b1;
        bus.data_in = 10'd5;
        bus.ack_out = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.ack_in !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ack_in: got %b want 0", bus.ack_in);
        end
        n_checks++;
        if (bus.req_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req_out: got %b want 0", bus.req_out);
        end
        n_checks++;
        if (dut.pot_q !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_pot: got %0d want 0", dut.pot_q);
        end
        bus.req_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.ack_in !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_late_ack: got %b want 0", bus.ack_in);
        end
        $display("test_reset done");
    endtask

    task automatic test_accumulate();
        bit f, ok;
        logic [9:0] w [2] = '{10'd300, 10'd300};
        bit         ef [2] = '{1'b0, 1'b1};
        int         ep [2] = '{300, 0};
        pulse_reset();
        for (int k = 0; k < 2; k++) begin
            send_event(w[k], f, ok);
            n_checks++;
            if (ok !== 1'b1 || f !== ef[k]) begin
                n_fail++;
                $display("FAIL accum_event%0d: ok=%b fired=%b want ok=1 fired=%b", k, ok, f, ef[k]);
            end
            n_checks++;
            if (dut.pot_q !== 11'(ep[k])) begin
                n_fail++;
                $display("FAIL accum_pot%0d: got %0d want %0d", k, dut.pot_q, ep[k]);
            end
            $display("accumulate event w=%0d fired=%b pot=%0d", w[k], f, dut.pot_q);
        end
    endtask

    task automatic test_threshold();
        bit f, ok;
        logic [9:0] w [5] = '{10'd511, 10'd1, 10'd512, 10'd1023, 10'd0};
        bit         ef [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        int         ep [5] = '{511, 0, 0, 0, 0};
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            send_event(w[k], f, ok);
            n_checks++;
            if (ok !== 1'b1 || f !== ef[k]) begin
                n_fail++;
                $display("FAIL thresh_event%0d: ok=%b fired=%b want ok=1 fired=%b", k, ok, f, ef[k]);
            end
            n_checks++;
            if (dut.pot_q !== 11'(ep[k])) begin
                n_fail++;
                $display("FAIL thresh_pot%0d: got %0d want %0d", k, dut.pot_q, ep[k]);
            end
            $display("threshold event w=%0d fired=%b pot=%0d", w[k], f, dut.pot_q);
        end
    endtask

    task automatic test_handshake_timing();
        int n;
        int good;
        pulse_reset();
        // Rise: edge E samples req_in, ack_in high after edge E+3 (4th edge)
        @(negedge clk);
        bus.data_in = 10'd5;
        bus.req_in = 1'b1;
        n = 0;
        for (int i = 0; i < 30 && !bus.ack_in; i++) begin
            @(posedge clk); #1; n++;
        end
        n_checks++;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL ack_rise_edges: got %0d want 4", n);
        end
        // Long request: ack_in must hold while req_in stays high
        good = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.ack_in === 1'b1) good++;
        end
        n_checks++;
        if (good !== 10) begin
            n_fail++;
            $display("FAIL ack_hold: got %0d cycles want 10", good);
        end
        bus.req_in = 1'b0;
        n = 0;
        for (int i = 0; i < 30 && bus.ack_in; i++) begin
            @(posedge clk); #1; n++;
        end
        n_checks++;
        if (n !== 3) begin
            n_fail++;
            $display("FAIL ack_fall_edges: got %0d want 3", n);
        end
        $display("handshake w=5 pot=%0d", dut.pot_q);
        // Firing event 507 on pot 5: spike one edge after ack_in falls
        @(negedge clk);
        bus.data_in = 10'd507;
        bus.req_in = 1'b1;
        for (int i = 0; i < 30 && !bus.ack_in; i++) @(negedge clk);
        bus.req_in = 1'b0;
        for (int i = 0; i < 30 && bus.ack_in; i++) begin
            @(posedge clk); #1;
        end
        n = 0;
        for (int i = 0; i < 30 && !bus.req_out; i++) begin
            @(posedge clk); #1; n++;
        end
        n_checks++;
        if (n !== 1) begin
            n_fail++;
            $display("FAIL req_rise_edges: got %0d want 1", n);
        end
        // Stall downstream for 20 cycles while a new request waits
        @(negedge clk);
        bus.data_in = 10'd7;
        bus.req_in = 1'b1;
        good = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_out === 1'b1 && bus.ack_in === 1'b0) good++;
        end
        n_checks++;
        if (good !== 20) begin
            n_fail++;
            $display("FAIL stall_block: got %0d cycles want 20", good);
        end
        bus.ack_out = 1'b1;
        n = 0;
        for (int i = 0; i < 30 && bus.req_out; i++) begin
            @(posedge clk); #1; n++;
        end
        n_checks++;
        if (n !== 3) begin
            n_fail++;
            $display("FAIL req_fall_edges: got %0d want 3", n);
        end
        @(negedge clk);
        bus.ack_out = 1'b0;
        // Pending request acked: 3 edges to IDLE, 1 to INTEG, 1 to ack
        n = 0;
        for (int i = 0; i < 30 && !bus.ack_in; i++) begin
            @(posedge clk); #1; n++;
        end
        n_checks++;
        if (n !== 5) begin
            n_fail++;
            $display("FAIL next_accept_edges: got %0d want 5", n);
        end
        @(negedge clk);
        bus.req_in = 1'b0;
        for (int i = 0; i < 30 && bus.ack_in; i++) @(negedge clk);
        n_checks++;
        if (dut.pot_q !== 11'd7) begin
            n_fail++;
            $display("FAIL stall_pot: got %0d want 7", dut.pot_q);
        end
        $display("handshake fire+stall pot=%0d", dut.pot_q);
    endtask

    task automatic test_sequence();
        bit f, ok;
        int spikes = 0;
        int exp_spikes = 0;
        int exp_pot = 0;
        int all_ok = 1;
        int wl [20] = '{100, 250, 200, 37, 511, 1, 0, 600, 1023, 45,
                        300, 212, 99, 400, 13, 512, 256, 255, 1, 700};
        pulse_reset();
        proto_err = 0;
        for (int k = 0; k < 20; k++) begin
            exp_pot = exp_pot + wl[k];
            if (exp_pot >= 512) begin
                exp_spikes++;
                exp_pot = 0;
            end
            send_event(10'(wl[k]), f, ok);
            if (f) spikes++;
            if (!ok) all_ok = 0;
            $display("sequence event %0d w=%0d fired=%b pot=%0d", k, wl[k], f, dut.pot_q);
        end
        n_checks++;
        if (all_ok !== 1) begin
            n_fail++;
            $display("FAIL seq_handshakes: got ok=%0d want 1", all_ok);
        end
        n_checks++;
        if (spikes !== exp_spikes) begin
            n_fail++;
            $display("FAIL seq_spikes: got %0d want %0d", spikes, exp_spikes);
        end
        n_checks++;
        if (dut.pot_q !== 11'(exp_pot)) begin
            n_fail++;
            $display("FAIL seq_pot: got %0d want %0d", dut.pot_q, exp_pot);
        end
        n_checks++;
        if (proto_err !== 0) begin
            n_fail++;
            $display("FAIL seq_overlap: got %0d want 0", proto_err);
        end
    endtask

    task automatic test_reset_mid();
        bit f, ok;
        pulse_reset();
        @(negedge clk);
        bus.data_in = 10'd400;
        bus.req_in = 1'b1;
        for (int i = 0; i < 30 && !bus.ack_in; i++) @(negedge clk);
        n_checks++;
        if (bus.ack_in !== 1'b1 || dut.pot_q !== 11'd400) begin
            n_fail++;
            $display("FAIL mid_pre: ack=%b pot=%0d want ack=1 pot=400", bus.ack_in, dut.pot_q);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.ack_in !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_drop: got %b want 0", bus.ack_in);
        end
        bus.req_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut.pot_q !== 11'd0) begin
            n_fail++;
            $display("FAIL mid_pot_cleared: got %0d want 0", dut.pot_q);
        end
        send_event(10'd200, f, ok);
        n_checks++;
        if (ok !== 1'b1 || f !== 1'b0 || dut.pot_q !== 11'd200) begin
            n_fail++;
            $display("FAIL mid_next_event: ok=%b fired=%b pot=%0d want 1 0 200", ok, f, dut.pot_q);
        end
        $display("reset_mid next event w=200 fired=%b pot=%0d", f, dut.pot_q);
    endtask

    initial begin
        rst = 1'b0;
        bus.req_in = 1'b0;
        bus.ack_out = 1'b0;
        bus.data_in = '0;
        test_reset();
        test_accumulate();
        test_threshold();
        test_handshake_timing();
        test_sequence();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
